// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle sprite controller and datapath:
// state encoding, screen geometry and a counter-width helper.
package obstacle_pkg;

    // Controller state encoding (3-bit)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAW  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ERASE = 3'd3;
    localparam logic [2:0] S_MOVE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_DRAW  = S_DRAW,
        ST_WAIT  = S_WAIT,
        ST_ERASE = S_ERASE,
        ST_MOVE  = S_MOVE
    } state_e;

    // VGA screen geometry in sprite-grid pixels
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Counter width for a modulus of n; never collapses to zero bits
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obstacle_ctrl_frame_tick_gen.sv
// Hold-time generator for the WAIT state: a tick counter producing one pulse
// per frame and a frame counter advanced by that pulse. Held at zero while
// clear is high so every WAIT interval starts from the same point.
module frame_tick_gen
    import obstacle_pkg::*;
#(
    parameter int TICK_CYCLES     = 833_333,
    parameter int FRAMES_PER_MOVE = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick,
    output logic hold_done
);

    localparam int TW = cnt_w(TICK_CYCLES);
    localparam int FW = cnt_w(FRAMES_PER_MOVE);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] frame_q, frame_d;

    // Next-count logic: tick wraps each frame, frame advances on every tick
    always_comb begin
        tick      = (tick_q == TICK_LAST);
        hold_done = tick && (frame_q == FRAME_LAST);
        tick_d    = tick_q;
        frame_d   = frame_q;
        if (clear) begin
            tick_d  = '0;
            frame_d = '0;
        end else if (tick) begin
            tick_d  = '0;
            frame_d = hold_done ? '0 : frame_q + FW'(1);
        end else begin
            tick_d  = tick_q + TW'(1);
        end
    end

    // Counter registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/obstacle_ctrl.sv
// Obstacle sprite control FSM: draw the 4x4 sprite one pixel per cycle, hold
// it for a fixed number of frames, erase it, then pulse a position update.
// Outputs are registered copies of the decode of the next state, so they
// track the registered state exactly and never glitch.
module obstacle_ctrl
    import obstacle_pkg::*;
#(
    parameter int TICK_CYCLES     = 833_333,
    parameter int FRAMES_PER_MOVE = 15,
    parameter int PIXEL_COUNT     = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic start,
    input  logic stop,
    output logic go,
    output logic plot,
    output logic erase,
    output logic move,
    output logic busy
);

    localparam int PW = cnt_w(PIXEL_COUNT);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_COUNT - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          stop_req_q, stop_req_d;
    logic          go_q, go_d;
    logic          plot_q, plot_d;
    logic          erase_q, erase_d;
    logic          move_q, move_d;
    logic          busy_q, busy_d;
    logic          hold_done;
    logic          frame_tick;
    logic          pix_last;

    // Hold timer only runs in WAIT; held cleared elsewhere so entry is exact
    frame_tick_gen #(
        .TICK_CYCLES    (TICK_CYCLES),
        .FRAMES_PER_MOVE(FRAMES_PER_MOVE)
    ) u_tick (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (state_q != ST_WAIT),
        .tick     (frame_tick),
        .hold_done(hold_done)
    );

    assign pix_last = (pix_q == PIX_LAST);

    // Next state, pixel counter, stop latch and Moore decode of next state
    always_comb begin
        state_d    = state_q;
        pix_d      = '0;
        stop_req_d = stop_req_q | stop;
        case (state_q)
            ST_IDLE: begin
                // stop only counts here if it arrives together with start
                stop_req_d = start & stop;
                if (start) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (pix_last) state_d = ST_WAIT;
                else          pix_d   = pix_q + PW'(1);
            end
            ST_WAIT: begin
                if (hold_done) state_d = ST_ERASE;
            end
            ST_ERASE: begin
                if (pix_last) state_d = stop_req_q ? ST_IDLE : ST_MOVE;
                else          pix_d   = pix_q + PW'(1);
            end
            ST_MOVE: begin
                state_d = ST_DRAW;
            end
            default: begin
                state_d    = ST_IDLE;
                stop_req_d = 1'b0;
            end
        endcase

        go_d    = (state_d == ST_DRAW) || (state_d == ST_ERASE);
        plot_d  = go_d;
        erase_d = (state_d == ST_ERASE);
        move_d  = (state_d == ST_MOVE);
        busy_d  = (state_d != ST_IDLE);
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            pix_q      <= '0;
            stop_req_q <= 1'b0;
            go_q       <= 1'b0;
            plot_q     <= 1'b0;
            erase_q    <= 1'b0;
            move_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            stop_req_q <= stop_req_d;
            go_q       <= go_d;
            plot_q     <= plot_d;
            erase_q    <= erase_d;
            move_q     <= move_d;
            busy_q     <= busy_d;
        end
    end

    assign go    = go_q;
    assign plot  = plot_q;
    assign erase = erase_q;
    assign move  = move_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Directed bench for obstacle_ctrl with TICK_CYCLES=4, FRAMES_PER_MOVE=2,
// PIXEL_COUNT=16: WAIT is 8 cycles, a full step is 41 cycles.
module tb_obstacle_ctrl;

    logic clock = 1'b0;
    logic resetn, start, stop;
    logic go, plot, erase, move, busy;

    always #5 clock = ~clock;

    obstacle_ctrl #(
        .TICK_CYCLES    (4),
        .FRAMES_PER_MOVE(2),
        .PIXEL_COUNT    (16)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .start (start),
        .stop  (stop),
        .go    (go),
        .plot  (plot),
        .erase (erase),
        .move  (move),
        .busy  (busy)
    );

    // Expected output bundles {go, plot, erase, move, busy}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_DRAW  = 5'b11001;
    localparam logic [4:0] O_WAIT  = 5'b00001;
    localparam logic [4:0] O_ERASE = 5'b11101;
    localparam logic [4:0] O_MOVE  = 5'b00011;

    typedef struct {
        logic       rstn;
        logic       st;
        logic       sp;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int n, input logic r, input logic s, input logic p,
                       input logic [4:0] e);
        for (int i = 0; i < n; i++) vecs.push_back('{r, s, p, e});
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        int   n;
        int   gocnt;
        int   mvcnt;
        logic found;

        resetn = 1'b0; start = 1'b0; stop = 1'b0;

        // Reset, then idle held
        add(2, 0, 0, 0, O_IDLE);
        add(5, 1, 0, 0, O_IDLE);
        // Single step followed by a second step with stop during WAIT cycle 3
        add(1, 1, 1, 0, O_DRAW);
        add(15, 1, 0, 0, O_DRAW);
        add(8, 1, 0, 0, O_WAIT);
        add(16, 1, 0, 0, O_ERASE);
        add(1, 1, 0, 0, O_MOVE);
        add(16, 1, 0, 0, O_DRAW);
        add(3, 1, 0, 0, O_WAIT);
        add(1, 1, 0, 1, O_WAIT);
        add(4, 1, 0, 0, O_WAIT);
        add(16, 1, 0, 0, O_ERASE);
        add(4, 1, 0, 0, O_IDLE);
        // start and stop together in IDLE: one step, no move, busy 40 cycles
        add(1, 1, 1, 1, O_DRAW);
        add(15, 1, 0, 0, O_DRAW);
        add(8, 1, 0, 0, O_WAIT);
        add(16, 1, 0, 0, O_ERASE);
        add(3, 1, 0, 0, O_IDLE);
        // Reset during ERASE cycle 5, then a full DRAW after restart
        add(1, 1, 1, 0, O_DRAW);
        add(15, 1, 0, 0, O_DRAW);
        add(8, 1, 0, 0, O_WAIT);
        add(5, 1, 0, 0, O_ERASE);
        add(1, 0, 0, 0, O_IDLE);
        add(2, 1, 0, 0, O_IDLE);
        add(1, 1, 1, 0, O_DRAW);
        add(15, 1, 0, 0, O_DRAW);
        add(1, 1, 0, 0, O_WAIT);
        add(1, 0, 0, 0, O_IDLE);
        // start held high: period stays 41, DRAW never restarts early
        add(16, 1, 1, 0, O_DRAW);
        add(8, 1, 1, 0, O_WAIT);
        add(16, 1, 1, 0, O_ERASE);
        add(1, 1, 1, 0, O_MOVE);
        add(16, 1, 1, 0, O_DRAW);
        add(8, 1, 1, 0, O_WAIT);
        add(16, 1, 1, 0, O_ERASE);
        add(1, 1, 1, 0, O_MOVE);
        add(16, 1, 1, 0, O_DRAW);
        add(1, 0, 0, 0, O_IDLE);

        foreach (vecs[i]) begin
            @(negedge clock);
            resetn = vecs[i].rstn;
            start  = vecs[i].st;
            stop   = vecs[i].sp;
            @(posedge clock);
            #1;
            check("outputs", i, {go, plot, erase, move, busy}, vecs[i].exp);
        end

        // Continuous run: measure the move-to-move period and go activity
        @(negedge clock);
        resetn = 1'b1; start = 1'b1; stop = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock); #1;
            if (move) found = 1'b1;
        end
        check("first_move_seen", 0, found, 1);
        n = 0; gocnt = 0; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock); #1;
            n++;
            if (go) gocnt++;
            if (move) begin
                found = 1'b1;
                check("move_go_exclusive", n, go | plot, 0);
            end
        end
        check("step_period", 0, n, 41);
        check("go_cycles_per_step", 0, gocnt, 32);

        // Stop raised in DRAW: step finishes, no move, returns to IDLE
        @(negedge clock);
        start = 1'b0; stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        found = 1'b0; mvcnt = 0; n = 1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clock); #1;
            n++;
            if (move) mvcnt++;
            if (!busy) found = 1'b1;
        end
        check("stop_reaches_idle", 0, found, 1);
        check("stop_no_move", 0, mvcnt, 0);
        check("stop_idle_outputs", 0, {go, plot, erase, move, busy}, O_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
